// File: rtl/ace_pkg.sv
// rtl/ace_pkg.sv - shared ACE encodings, transaction kinds and adapter states
package ace_pkg;
    localparam logic [3:0] ARSNOOP_READ_SHARED  = 4'b0001;
    localparam logic [3:0] ARSNOOP_CLEAN_UNIQUE = 4'b1011;
    localparam logic [2:0] AWSNOOP_WRITE_BACK   = 3'b011;
    localparam logic [1:0] RESP_OKAY            = 2'b00;

    typedef enum logic [1:0] {
        TXN_READ,
        TXN_CLEAN,
        TXN_WB
    } txn_kind_t;

    typedef enum logic [2:0] {
        IDLE,
        AR_SEND,
        R_WAIT,
        WR_SEND,
        B_WAIT,
        ACK
    } adapter_state_t;
endpackage

// File: rtl/ace_wr_channel.sv
// rtl/ace_wr_channel.sv - AW/W issue with independent completion tracking
module ace_wr_channel (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_awready,
    input  logic i_wready,
    output logic o_awvalid,
    output logic o_wvalid,
    output logic o_wr_sent
);
    logic r_aw_done;
    logic r_w_done;
    logic w_aw_hs;
    logic w_w_hs;

    assign o_awvalid = i_active & ~r_aw_done;
    assign o_wvalid  = i_active & ~r_w_done;
    assign w_aw_hs   = o_awvalid & i_awready;
    assign w_w_hs    = o_wvalid & i_wready;
    // Fires in the cycle the later of the two handshakes lands (or both together).
    assign o_wr_sent = i_active & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else if (o_wr_sent) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end
endmodule

// File: rtl/ace_request_adapter.sv
// rtl/ace_request_adapter.sv - cache request lines to ACE ReadShared/CleanUnique/WriteBack
module ace_request_adapter
    import ace_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read_req,
    input  logic                  i_write_req,
    input  logic                  i_invalid_req,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    output logic                  o_ace_ready,
    output logic                  o_ace_err,
    output logic [DATA_WIDTH-1:0] o_fill_data,
    output logic                  o_fill_shared,
    output logic                  o_fill_dirty,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [3:0]            o_arsnoop,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [3:0]            i_rresp,
    output logic                  o_rack,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [2:0]            o_awsnoop,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wlast,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_wack
);
    adapter_state_t        r_state;
    adapter_state_t        w_next_state;
    txn_kind_t             r_kind;
    txn_kind_t             w_req_kind;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_arsnoop;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_fill_data;
    logic                  r_fill_shared;
    logic                  r_fill_dirty;
    logic                  w_any_req;
    logic                  w_capture;
    logic                  w_wr_active;
    logic                  w_wr_sent;

    // Writeback wins so a dirty victim leaves before its replacement is fetched.
    assign w_req_kind = i_write_req   ? TXN_WB :
                        i_invalid_req ? TXN_CLEAN : TXN_READ;
    assign w_any_req   = i_write_req | i_invalid_req | i_read_req;
    assign w_capture   = (r_state == IDLE) & w_any_req;
    assign w_wr_active = (r_state == WR_SEND);

    ace_wr_channel u_wr_channel (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_wr_active),
        .i_awready (i_awready),
        .i_wready  (i_wready),
        .o_awvalid (o_awvalid),
        .o_wvalid  (o_wvalid),
        .o_wr_sent (w_wr_sent)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_rready     = 1'b0;
        o_bready     = 1'b0;
        o_arvalid    = 1'b0;
        o_ace_ready  = 1'b0;
        o_rack       = 1'b0;
        o_wack       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) w_next_state = (w_req_kind == TXN_WB) ? WR_SEND : AR_SEND;
            end
            AR_SEND: begin
                o_arvalid = 1'b1;
                if (i_arready) w_next_state = R_WAIT;
            end
            R_WAIT: begin
                o_rready = 1'b1;
                if (i_rvalid) w_next_state = ACK;
            end
            WR_SEND: begin
                if (w_wr_sent) w_next_state = B_WAIT;
            end
            B_WAIT: begin
                o_bready = 1'b1;
                if (i_bvalid) w_next_state = ACK;
            end
            ACK: begin
                o_ace_ready  = 1'b1;
                o_rack       = (r_kind != TXN_WB);
                o_wack       = (r_kind == TXN_WB);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind        <= TXN_READ;
            r_addr        <= '0;
            r_data        <= '0;
            r_arsnoop     <= '0;
            r_err         <= 1'b0;
            r_fill_data   <= '0;
            r_fill_shared <= 1'b0;
            r_fill_dirty  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_kind    <= w_req_kind;
                r_addr    <= i_req_addr;
                r_arsnoop <= (w_req_kind == TXN_CLEAN) ? ARSNOOP_CLEAN_UNIQUE : ARSNOOP_READ_SHARED;
                if (w_req_kind == TXN_WB) r_data <= i_wb_data;
            end
            if ((r_state == R_WAIT) && i_rvalid) begin
                r_err <= (i_rresp[1:0] != RESP_OKAY);
                if (r_kind == TXN_READ) begin
                    r_fill_data   <= i_rdata;
                    r_fill_shared <= i_rresp[3];
                    r_fill_dirty  <= i_rresp[2];
                end
            end
            if ((r_state == B_WAIT) && i_bvalid) r_err <= (i_bresp != RESP_OKAY);
        end
    end

    assign o_ace_err     = r_err & (r_state == ACK);
    assign o_fill_data   = r_fill_data;
    assign o_fill_shared = r_fill_shared;
    assign o_fill_dirty  = r_fill_dirty;
    assign o_araddr      = r_addr;
    assign o_arsnoop     = r_arsnoop;
    assign o_awaddr      = r_addr;
    assign o_awsnoop     = AWSNOOP_WRITE_BACK;
    assign o_wdata       = r_data;
    assign o_wlast       = 1'b1;
endmodule

// File: tb/tb_ace_request_adapter.sv
// tb/tb_ace_request_adapter.sv - scoreboard bench for ace_request_adapter
module tb_ace_request_adapter;
    import ace_pkg::*;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_read_req = 1'b0, i_write_req = 1'b0, i_invalid_req = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [DW-1:0] i_wb_data = '0;
    logic          o_ace_ready, o_ace_err, o_fill_shared, o_fill_dirty;
    logic [DW-1:0] o_fill_data;
    logic          o_arvalid, o_rready, o_rack, o_awvalid, o_wvalid, o_wlast, o_bready, o_wack;
    logic          i_arready = 1'b0, i_rvalid = 1'b0, i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
    logic [AW-1:0] o_araddr, o_awaddr;
    logic [3:0]    o_arsnoop;
    logic [2:0]    o_awsnoop;
    logic [DW-1:0] o_wdata;
    logic [DW-1:0] i_rdata = '0;
    logic [3:0]    i_rresp = '0;
    logic [1:0]    i_bresp = '0;

    always #5 clk = ~clk;

    ace_request_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_read_req(i_read_req), .i_write_req(i_write_req), .i_invalid_req(i_invalid_req),
        .i_req_addr(i_req_addr), .i_wb_data(i_wb_data),
        .o_ace_ready(o_ace_ready), .o_ace_err(o_ace_err), .o_fill_data(o_fill_data),
        .o_fill_shared(o_fill_shared), .o_fill_dirty(o_fill_dirty),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arsnoop(o_arsnoop),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp), .o_rack(o_rack),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awsnoop(o_awsnoop),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp), .o_wack(o_wack)
    );

    typedef struct {
        txn_kind_t     kind;
        logic          err;
        logic [DW-1:0] fill;
        logic          sh;
        logic          dt;
    } done_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    snoop;
    } ar_t;

    done_t         done_q[$];
    ar_t           ar_q[$];
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    int            total = 0;
    int            bad = 0;
    int            ar_count = 0;

    // Reference cache-fill view: what the controller should see after each completion.
    logic [DW-1:0] m_fill = '0;
    logic          m_sh = 1'b0, m_dt = 1'b0;

    int            cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
    logic [DW-1:0] cfg_rdata = '0;
    logic [3:0]    cfg_rresp = '0;
    logic [1:0]    cfg_bresp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Interconnect model: each ready rises after its configured wait, only while valid is up.
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    always @(negedge clk) begin
        if (o_arvalid) begin
            if (ar_q.size() == 0) begin
                check("ar_unexpected", 64'd1, 64'd0);
                i_arready = 1'b1;
            end else begin
                check("araddr", 64'(o_araddr), 64'(ar_q[0].addr));
                check("arsnoop", 64'(o_arsnoop), 64'(ar_q[0].snoop));
                i_arready = (ar_c >= cfg_ar_dly);
                ar_c++;
                if (i_arready) begin
                    void'(ar_q.pop_front());
                    ar_count++;
                end
            end
        end else begin
            i_arready = 1'b0;
            ar_c = 0;
        end

        if (o_rready) begin
            i_rvalid = (r_c >= cfg_r_dly);
            r_c++;
            i_rdata = i_rvalid ? cfg_rdata : DW'($urandom());
            i_rresp = i_rvalid ? cfg_rresp : 4'($urandom());
        end else begin
            i_rvalid = 1'b0;
            r_c = 0;
        end

        if (o_awvalid) begin
            if (aw_q.size() == 0) begin
                check("aw_unexpected", 64'd1, 64'd0);
                i_awready = 1'b1;
            end else begin
                i_awready = (aw_c >= cfg_aw_dly);
                aw_c++;
                if (i_awready) begin
                    check("awaddr", 64'(o_awaddr), 64'(aw_q.pop_front()));
                    check("awsnoop", 64'(o_awsnoop), 64'h3);
                end
            end
        end else begin
            i_awready = 1'b0;
            aw_c = 0;
        end

        if (o_wvalid) begin
            if (w_q.size() == 0) begin
                check("w_unexpected", 64'd1, 64'd0);
                i_wready = 1'b1;
            end else begin
                i_wready = (w_c >= cfg_w_dly);
                w_c++;
                if (i_wready) begin
                    check("wdata", 64'(o_wdata), 64'(w_q.pop_front()));
                    check("wlast", 64'(o_wlast), 64'd1);
                end
            end
        end else begin
            i_wready = 1'b0;
            w_c = 0;
        end

        if (o_bready) begin
            i_bvalid = (b_c >= cfg_b_dly);
            b_c++;
            i_bresp = i_bvalid ? cfg_bresp : 2'($urandom());
        end else begin
            i_bvalid = 1'b0;
            b_c = 0;
        end
    end

    done_t mon_d;
    always @(negedge clk) begin
        if (reset && o_ace_ready) begin
            if (done_q.size() == 0) begin
                check("spurious_ace_ready", 64'd1, 64'd0);
            end else begin
                mon_d = done_q.pop_front();
                check("rack", 64'(o_rack), 64'(mon_d.kind != TXN_WB));
                check("wack", 64'(o_wack), 64'(mon_d.kind == TXN_WB));
                check("ace_err", 64'(o_ace_err), 64'(mon_d.err));
                check("fill_data", 64'(o_fill_data), 64'(mon_d.fill));
                check("fill_attr", 64'({o_fill_shared, o_fill_dirty}), 64'({mon_d.sh, mon_d.dt}));
            end
        end else if (reset && (o_ace_err || o_rack || o_wack)) begin
            check("strobes_outside_ack", 64'({o_ace_err, o_rack, o_wack}), 64'd0);
        end
    end

    task automatic scenario(input bit wr, input bit inv, input bit rd, input bit late_rd,
                            input bit inv_pulse, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wbd, input bit zero_wait);
        txn_kind_t kinds[$];
        done_t     d;
        ar_t       a;
        int        n;
        int        ar_start;
        int        ar_exp;
        ar_start = ar_count;
        ar_exp = 0;
        if (wr)  kinds.push_back(TXN_WB);
        if (inv) kinds.push_back(TXN_CLEAN);
        if (rd)  kinds.push_back(TXN_READ);
        foreach (kinds[k]) begin
            d.err = 1'b0;
            if (kinds[k] == TXN_WB) begin
                aw_q.push_back(addr);
                w_q.push_back(wbd);
                d.err = (cfg_bresp != 2'b00);
            end else begin
                a.addr  = addr;
                a.snoop = (kinds[k] == TXN_CLEAN) ? 4'b1011 : 4'b0001;
                ar_q.push_back(a);
                ar_exp++;
                d.err = (cfg_rresp[1:0] != 2'b00);
                if (kinds[k] == TXN_READ) begin
                    m_fill = cfg_rdata;
                    m_sh   = cfg_rresp[3];
                    m_dt   = cfg_rresp[2];
                end
            end
            d.kind = kinds[k];
            d.fill = m_fill;
            d.sh   = m_sh;
            d.dt   = m_dt;
            done_q.push_back(d);
        end
        @(negedge clk);
        i_req_addr    = addr;
        i_wb_data     = wbd;
        i_write_req   = wr;
        i_invalid_req = inv;
        i_read_req    = rd & !late_rd;
        for (int k = 0; k < kinds.size(); k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (inv_pulse) i_invalid_req = 1'b0;
            end while (!o_ace_ready && n < 200);
            if (!o_ace_ready) begin
                check("ace_ready_timeout", 64'd0, 64'd1);
                k = kinds.size();
            end else begin
                if (zero_wait) check("latency", 64'(n), (k == 0) ? 64'd3 : 64'd4);
                case (kinds[k])
                    TXN_WB:    i_write_req = 1'b0;
                    TXN_CLEAN: i_invalid_req = 1'b0;
                    default:   i_read_req = 1'b0;
                endcase
                if (late_rd && k == 0) i_read_req = 1'b1;
            end
        end
        i_write_req = 1'b0; i_invalid_req = 1'b0; i_read_req = 1'b0;
        repeat (3) @(negedge clk);
        check("ar_transactions", 64'(ar_count - ar_start), 64'(ar_exp));
        check("queues_drained", 64'(done_q.size() + ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
    endtask

    task automatic set_cfg(input int ard, input int rdl, input int awd, input int wd, input int bd,
                           input logic [DW-1:0] rdat, input logic [3:0] rr, input logic [1:0] br);
        cfg_ar_dly = ard; cfg_r_dly = rdl; cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd;
        cfg_rdata = rdat; cfg_rresp = rr; cfg_bresp = br;
    endtask

    initial begin
        int n;
        bit wr, inv, rd, pulse;
        #1;
        check("reset_ctrl", 64'({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                                 o_rack, o_wack, o_ace_ready, o_ace_err}), 64'd0);
        check("reset_fill", 64'({o_fill_data, o_fill_shared, o_fill_dirty}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        set_cfg(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 4'b1000, 2'b00);
        scenario(0, 0, 1, 0, 0, 32'h0000_1040, 32'h0, 1);

        set_cfg(0, 0, 3, 0, 0, 32'h0, 4'b0000, 2'b00);
        scenario(1, 0, 0, 0, 0, 32'h0000_2080, 32'h1234_5678, 0);

        set_cfg(2, 0, 0, 0, 0, 32'hAAAA_5555, 4'b0000, 2'b00);
        scenario(0, 1, 0, 0, 1, 32'h0000_30C0, 32'h0, 0);

        set_cfg(0, 0, 0, 0, 0, 32'hCAFE_F00D, 4'b0100, 2'b00);
        scenario(1, 0, 1, 1, 0, 32'h0000_4100, 32'h0BAD_C0DE, 1);

        set_cfg(0, 1, 0, 2, 1, 32'h1357_9BDF, 4'b1100, 2'b10);
        scenario(1, 0, 1, 0, 0, 32'h0000_5140, 32'h2468_ACE0, 0);

        // Reset while waiting on R: the read must vanish without a completion.
        set_cfg(0, 8, 0, 0, 0, 32'h7777_7777, 4'b0000, 2'b00);
        begin
            ar_t a;
            done_t d;
            a.addr = 32'h0000_6180; a.snoop = 4'b0001;
            ar_q.push_back(a);
            d.kind = TXN_READ; d.err = 1'b0; d.fill = '0; d.sh = 1'b0; d.dt = 1'b0;
            done_q.push_back(d);
        end
        @(negedge clk);
        i_req_addr = 32'h0000_6180;
        i_read_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_rready && n < 50);
        check("reached_r_wait", 64'(o_rready), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                                       o_rack, o_wack, o_ace_ready, o_ace_err}), 64'd0);
        check("async_reset_fill", 64'({o_fill_data, o_fill_shared, o_fill_dirty}), 64'd0);
        check("async_reset_addr", 64'({o_araddr, o_wdata}), 64'd0);
        i_read_req = 1'b0;
        done_q.delete(); ar_q.delete(); aw_q.delete(); w_q.delete();
        m_fill = '0; m_sh = 1'b0; m_dt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 64'({o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_ace_ready}), 64'd0);

        set_cfg(0, 0, 0, 0, 0, 32'h0F0F_1E1E, 4'b1100, 2'b00);
        scenario(0, 0, 1, 0, 0, 32'h0000_7000, 32'h0, 1);

        for (int it = 0; it < 40; it++) begin
            wr  = 1'($urandom());
            inv = 1'($urandom());
            rd  = 1'($urandom());
            if (!(wr || inv || rd)) rd = 1'b1;
            pulse = inv && !wr && !rd && 1'($urandom());
            set_cfg(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), DW'($urandom()), 4'($urandom()),
                    ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00);
            if (it % 4 == 0) set_cfg(0, 0, 0, 0, 0, cfg_rdata, cfg_rresp, cfg_bresp);
            scenario(wr, inv, rd, 0, pulse, $urandom() & 32'hFFFF_FFC0, DW'($urandom()),
                     (cfg_ar_dly + cfg_r_dly + cfg_aw_dly + cfg_w_dly + cfg_b_dly) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
